// File: rtl/msk_tof_issue.sv
// msk_tof_issue: issue stage for a masked AND-XOR gadget (out = a&b ^ c).
// A randomness FIFO supplies one fresh word per issued operation. A
// three-stage valid pipeline presents operands to the external gadget in two
// latency groups and flags the result three cycles after acceptance.
// Build option: define MSK_TOF_ISSUE_ZEROIZE_EN to clear S1/S2 data registers
// on bubbles. When it is undefined, the data registers hold their last values.
// Shares are only moved and registered here. They are never combined.
// d must be >= 2, so that at least one random bit exists per operation.
module msk_tof_issue #(
  parameter int unsigned d     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // operation handshake
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [d-1:0]             in_a,
  input  logic [d-1:0]             in_b,
  input  logic [d-1:0]             in_c,
  // fresh randomness handshake
  input  logic                     rnd_in_valid,
  output logic                     rnd_in_ready,
  input  logic [d*(d-1)/2-1:0]     rnd_in,
  // gadget inputs, latency-0 group
  output logic [d-1:0]             g_inb,
  output logic [d*(d-1)/2-1:0]     g_rnd,
  // gadget inputs, latency-1 group
  output logic [d-1:0]             g_ina,
  output logic [d-1:0]             g_inc,
  output logic [d-1:0]             g_inb_prev,
  // gadget result
  input  logic [d-1:0]             g_out,
  // result stream
  output logic                     out_valid,
  output logic [d-1:0]             out_data,
  output logic                     busy
);

  localparam int unsigned RW = d * (d - 1) / 2;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // ---------------------------------------------------------------------------
  // Randomness FIFO
  // ---------------------------------------------------------------------------
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [RW-1:0] fifo_head;

  // Readiness comes from registered state only.
  // rnd_in_ready is additionally gated by rst_n, so it reads 0 while reset is
  // held (count is 0 then, which would otherwise show the FIFO as not full).
  assign in_ready     = (count_q != '0);
  assign rnd_in_ready = rst_n & (count_q < CW'(DEPTH));

  assign push      = rnd_in_valid & rnd_in_ready;
  assign pop       = in_valid & in_ready;
  assign fifo_head = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy. Pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers. Reset discards any buffered randomness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage. It needs no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rnd_in;
  end

  // ---------------------------------------------------------------------------
  // Issue pipeline
  // ---------------------------------------------------------------------------
  logic          s1_valid_q, s1_valid_d;
  logic [d-1:0]  s1_a_q, s1_a_d;
  logic [d-1:0]  s1_b_q, s1_b_d;
  logic [d-1:0]  s1_c_q, s1_c_d;
  logic [RW-1:0] s1_rnd_q, s1_rnd_d;

  logic          s2_valid_q, s2_valid_d;
  logic [d-1:0]  s2_a_q, s2_a_d;
  logic [d-1:0]  s2_c_q, s2_c_d;
  logic [d-1:0]  s2_bprev_q, s2_bprev_d;

  logic          s3_valid_q, s3_valid_d;

  // Stage advance. The valid bits always shift. The data registers load on a
  // valid beat. On a bubble they either hold or clear, depending on the build.
  always_comb begin
    s1_valid_d = pop;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_rnd_d   = s1_rnd_q;
    if (pop) begin
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_c_d   = in_c;
      s1_rnd_d = fifo_head;
    end else begin
`ifdef MSK_TOF_ISSUE_ZEROIZE_EN
      s1_a_d   = '0;
      s1_b_d   = '0;
      s1_c_d   = '0;
      s1_rnd_d = '0;
`endif
    end

    s2_valid_d = s1_valid_q;
    s2_a_d     = s2_a_q;
    s2_c_d     = s2_c_q;
    s2_bprev_d = s2_bprev_q;
    if (s1_valid_q) begin
      s2_a_d     = s1_a_q;
      s2_c_d     = s1_c_q;
      s2_bprev_d = s1_b_q;
    end else begin
`ifdef MSK_TOF_ISSUE_ZEROIZE_EN
      s2_a_d     = '0;
      s2_c_d     = '0;
      s2_bprev_d = '0;
`endif
    end

    s3_valid_d = s2_valid_q;
  end

  // Pipeline registers. Reset drops every in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_rnd_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_c_q     <= '0;
      s2_bprev_q <= '0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_rnd_q   <= s1_rnd_d;
      s2_valid_q <= s2_valid_d;
      s2_a_q     <= s2_a_d;
      s2_c_q     <= s2_c_d;
      s2_bprev_q <= s2_bprev_d;
      s3_valid_q <= s3_valid_d;
    end
  end

  // Gadget drive. The result is passed through from the gadget in S3.
  assign g_inb      = s1_b_q;
  assign g_rnd      = s1_rnd_q;
  assign g_ina      = s2_a_q;
  assign g_inc      = s2_c_q;
  assign g_inb_prev = s2_bprev_q;

  assign out_valid  = s3_valid_q;
  assign out_data   = g_out;
  assign busy       = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: tb/tb_msk_tof_issue.sv
// Directed bench for msk_tof_issue (d=2, DEPTH=4) with a registered DOM-style
// AND gadget model attached to the g_* ports.
module tb_msk_tof_issue;

  localparam int unsigned D     = 2;
  localparam int unsigned DEPTH = 4;
`ifdef MSK_TOF_ISSUE_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [D-1:0] in_a, in_b, in_c;
  logic         rnd_in_valid, rnd_in_ready;
  logic [0:0]   rnd_in;
  logic [D-1:0] g_inb;
  logic [0:0]   g_rnd;
  logic [D-1:0] g_ina, g_inc, g_inb_prev;
  logic [D-1:0] g_out;
  logic         out_valid;
  logic [D-1:0] out_data;
  logic         busy;

  int n_total;
  int n_pass;
  int n_fail;
  int n_ov;

  msk_tof_issue #(.d(D), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_c         (in_c),
    .rnd_in_valid (rnd_in_valid),
    .rnd_in_ready (rnd_in_ready),
    .rnd_in       (rnd_in),
    .g_inb        (g_inb),
    .g_rnd        (g_rnd),
    .g_ina        (g_ina),
    .g_inc        (g_inc),
    .g_inb_prev   (g_inb_prev),
    .g_out        (g_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-share masked AND with XOR: out = a&b ^ c. Cross terms are refreshed by r.
  function automatic logic [1:0] dom_and(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c, input logic r);
    logic o0, o1;
    o0 = (a[0] & b[0]) ^ ((a[0] & b[1]) ^ r) ^ c[0];
    o1 = (a[1] & b[1]) ^ ((a[1] & b[0]) ^ r) ^ c[1];
    return {o1, o0};
  endfunction

  // Gadget model. It captures rnd in S1, computes in S2 and holds the result in S3.
  logic       gm_r;
  logic [1:0] gm_out;
  always @(posedge clk) begin
    gm_r   <= g_rnd[0];
    gm_out <= dom_and(g_ina, g_inb_prev, g_inc, gm_r);
  end
  assign g_out = gm_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    rnd_in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; rnd_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic w);
    rnd_in_valid = 1'b1;
    rnd_in       = w;
    tick();
    rnd_in_valid = 1'b0;
  endtask

  logic [1:0] va [8];
  logic [1:0] vb [8];
  logic [1:0] vc [8];
  logic       vw [9];

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; n_ov = 0;
    va = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01};
    vb = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
    vc = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
    vw = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Behaviour while reset is held.
    rst_n = 1'b0;
    in_valid = 1'b0; rnd_in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; rnd_in = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_rnd_ready", rnd_in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_g_all", {g_inb, g_rnd, g_ina, g_inc, g_inb_prev}, 0);
    rst_n = 1'b1;
    #1;
    check("rel_rnd_ready", rnd_in_ready, 1);

    // Single operation: stage alignment and latency.
    push_word(1'b1);
    check("t1_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = 2'b01; in_b = 2'b11; in_c = 2'b00;
    tick();
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    check("t1_s1_inb", g_inb, 2'b11);
    check("t1_s1_rnd", g_rnd, 1);
    check("t1_s1_busy", busy, 1);
    check("t1_s1_ov", out_valid, 0);
    check("t1_s1_in_ready", in_ready, 0);
    tick();
    check("t1_s2_ina", g_ina, 2'b01);
    check("t1_s2_inc", g_inc, 2'b00);
    check("t1_s2_bprev", g_inb_prev, 2'b11);
    check("t1_s2_ov", out_valid, 0);
    tick();
    check("t1_s3_ov", out_valid, 1);
    check("t1_s3_data", out_data, 2'b11);
    check("t1_s3_unmasked", ^out_data, 0);
    tick();
    check("t1_post_ov", out_valid, 0);
    check("t1_post_busy", busy, 0);

    // Fill to full, then run a pop alone and a simultaneous push and pop.
    do_reset();
    rnd_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd_in = 1'(i);
      tick();
      check("t2_fill_rnd_ready", rnd_in_ready, (i < 3) ? 1 : 0);
    end
    rnd_in_valid = 1'b0;
    check("t2_full_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = 2'b10; in_b = 2'b01; in_c = 2'b11;
    tick();
    in_valid = 1'b0;
    check("t2_pop_rnd", g_rnd, 0);
    check("t2_pop_rnd_ready", rnd_in_ready, 1);
    in_valid = 1'b1; rnd_in_valid = 1'b1; rnd_in = 1'b1;
    tick();
    in_valid = 1'b0; rnd_in_valid = 1'b0;
    check("t2_pp_rnd", g_rnd, 1);
    check("t2_pp_in_ready", in_ready, 1);
    check("t2_pp_rnd_ready", rnd_in_ready, 1);
    push_word(1'b0);
    check("t2_refull_rnd_ready", rnd_in_ready, 0);

    // Empty FIFO: requests stall until one word arrives.
    do_reset();
    in_valid = 1'b1; in_a = 2'b11; in_b = 2'b10; in_c = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stall_in_ready", in_ready, 0);
      check("t3_stall_ov", out_valid, 0);
    end
    push_word(1'b0);
    check("t3_word_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    n_ov = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) n_ov++;
      tick();
    end
    check("t3_one_out", n_ov, 1);
    check("t3_end_in_ready", in_ready, 0);

    // Eight back-to-back operations, with one randomness word per cycle.
    do_reset();
    push_word(vw[0]);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_c = vc[i];
      rnd_in_valid = 1'b1; rnd_in = vw[i+1];
      tick();
      check("t4_s1_rnd", g_rnd, vw[i]);
      check("t4_s1_inb", g_inb, vb[i]);
      if (i >= 2) begin
        check("t4_ov", out_valid, 1);
        check("t4_data", out_data, dom_and(va[i-2], vb[i-2], vc[i-2], vw[i-2]));
        check("t4_unmasked", ^out_data, ((^va[i-2]) & (^vb[i-2])) ^ (^vc[i-2]));
      end else begin
        check("t4_fill_ov", out_valid, 0);
      end
    end
    in_valid = 1'b0; rnd_in_valid = 1'b0;
    for (int j = 6; j < 8; j++) begin
      tick();
      check("t4_tail_ov", out_valid, 1);
      check("t4_tail_data", out_data, dom_and(va[j], vb[j], vc[j], vw[j]));
    end
    tick();
    check("t4_done_ov", out_valid, 0);
    check("t4_left_in_ready", in_ready, 1);

    // Reset one cycle after acceptance discards the operation.
    do_reset();
    push_word(1'b1);
    in_valid = 1'b1; in_a = 2'b01; in_b = 2'b01; in_c = 2'b10;
    tick();
    in_valid = 1'b0;
    check("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ov", out_valid, 0);
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_rnd_ready", rnd_in_ready, 0);
    check("t5_rst_inb", g_inb, 0);
    tick();
    rst_n = 1'b1;
    n_ov = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) n_ov++;
    end
    check("t5_no_out", n_ov, 0);
    check("t5_busy", busy, 0);
    check("t5_count0", in_ready, 0);

    // Bubble after an operation: data registers clear or hold, depending on the build.
    do_reset();
    push_word(1'b1);
    push_word(1'b0);
    in_valid = 1'b1; in_a = 2'b11; in_b = 2'b10; in_c = 2'b01;
    tick();
    in_valid = 1'b0;
    check("t6_s1_inb", g_inb, 2'b10);
    tick();
    check("t6_bub_inb", g_inb, ZEROIZE ? 2'b00 : 2'b10);
    check("t6_bub_rnd", g_rnd, ZEROIZE ? 1'b0 : 1'b1);
    check("t6_s2_ina", g_ina, 2'b11);
    tick();
    check("t6_bub_ina", g_ina, ZEROIZE ? 2'b00 : 2'b11);
    check("t6_bub_bprev", g_inb_prev, ZEROIZE ? 2'b00 : 2'b10);
    check("t6_s3_ov", out_valid, 1);
    tick();
    check("t6_end_ov", out_valid, 0);
    check("t6_end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
